// File: rtl/comparator_pkg.sv
// Shared types and defaults for the serial operand loader feeding the equality comparator.
package comparator_pkg;

  localparam int unsigned NBITS_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } loader_state_t;

endpackage

// File: rtl/shift_register_sipo.sv
// Serial-in parallel-out shift register, MSB first; clear+shift loads the bit as a fresh first bit.
module shift_register_sipo #(
  parameter int unsigned Nbits = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             d,
  output logic [Nbits-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (clear) begin
      q <= shift_en ? {{(Nbits-1){1'b0}}, d} : '0;
    end else if (shift_en) begin
      q <= {q[Nbits-2:0], d};
    end
  end

endmodule

// File: rtl/serial_word_loader.sv
// Assembles a serial MSB-first word, pairs it with a pattern snapshot and holds the pair
// under a valid/ready handshake for the downstream equality comparator.
module serial_word_loader
  import comparator_pkg::*;
#(
  parameter int unsigned Nbits = NBITS_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             pattern_load,
  input  logic [Nbits-1:0] pattern_in,
  output logic [Nbits-1:0] a_out,
  output logic [Nbits-1:0] b_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned CW = $clog2(Nbits);
  localparam logic [CW-1:0] LAST = CW'(Nbits - 1);

  loader_state_t    state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [Nbits-1:0] shreg;
  logic [Nbits-1:0] pattern_q;
  logic [Nbits-1:0] shifted_c;
  logic [Nbits-1:0] a_d, b_d;
  logic             sr_clear, sr_shift;
  logic             begin_word_c;
  logic             overrun_d;
  logic             unused_msb_c;

  shift_register_sipo #(.Nbits(Nbits)) u_sipo (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (sr_clear),
    .shift_en (sr_shift),
    .d        (serial_in),
    .q        (shreg)
  );

  // The register's MSB is always shifted out by the completing bit, so it never reaches a_out.
  assign shifted_c    = {shreg[Nbits-2:0], serial_in};
  assign unused_msb_c = shreg[Nbits-1];

  // Next-state, counter and output-register decode.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    a_d          = a_out;
    b_d          = b_out;
    sr_clear     = 1'b0;
    sr_shift     = 1'b0;
    begin_word_c = 1'b0;
    overrun_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        begin_word_c = start;
      end
      SHIFT: begin
        if (start) begin
          begin_word_c = 1'b1;
        end else if (bit_valid) begin
          if (count_q == LAST) begin
            a_d      = shifted_c;
            b_d      = pattern_load ? pattern_in : pattern_q;
            state_d  = HOLD;
            count_d  = '0;
            sr_clear = 1'b1;
          end else begin
            sr_shift = 1'b1;
            count_d  = count_q + CW'(1);
          end
        end
      end
      HOLD: begin
        if (word_ready) begin
          if (start) begin
            begin_word_c = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        overrun_d = bit_valid & ~(word_ready & start);
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase

    // A new word may take its MSB on the same cycle it starts.
    if (begin_word_c) begin
      state_d  = SHIFT;
      sr_clear = 1'b1;
      sr_shift = bit_valid;
      count_d  = bit_valid ? CW'(1) : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      pattern_q  <= '0;
      a_out      <= '0;
      b_out      <= '0;
      word_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      a_out      <= a_d;
      b_out      <= b_d;
      word_valid <= (state_d == HOLD);
      busy       <= (state_d == SHIFT);
      overrun    <= overrun_d;
      if (pattern_load) begin
        pattern_q <= pattern_in;
      end
    end
  end

endmodule

// File: tb/tb_serial_word_loader.sv
// Bench for serial_word_loader: directed scenarios plus randomized traffic against a queue-based model.
module tb_serial_word_loader;

  localparam int unsigned N = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         serial_in = 1'b0;
  logic         bit_valid = 1'b0;
  logic         pattern_load = 1'b0;
  logic         word_ready = 1'b0;
  logic [N-1:0] pattern_in = '0;
  logic [N-1:0] a_out, b_out;
  logic         word_valid, busy, overrun;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  serial_word_loader #(.Nbits(N)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .serial_in    (serial_in),
    .bit_valid    (bit_valid),
    .pattern_load (pattern_load),
    .pattern_in   (pattern_in),
    .a_out        (a_out),
    .b_out        (b_out),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .busy         (busy),
    .overrun      (overrun)
  );

  // Behavioural model: collected bits in a queue, a pending pair, a pattern value.
  bit           m_active = 1'b0;
  bit           m_pending = 1'b0;
  bit           m_ovr = 1'b0;
  logic [N-1:0] m_a = '0, m_b = '0, m_pat = '0;
  bit           m_bits[$];

  function automatic logic [N-1:0] pack_bits();
    logic [N-1:0] w = '0;
    foreach (m_bits[i]) w = {w[N-2:0], m_bits[i]};
    return w;
  endfunction

  task automatic model_step();
    bit ovr_n = 1'b0;
    if (!reset_n) begin
      m_active = 0; m_pending = 0; m_ovr = 0;
      m_a = '0; m_b = '0; m_pat = '0;
      m_bits.delete();
      return;
    end
    if (m_pending) begin
      if (bit_valid && !(word_ready && start)) ovr_n = 1'b1;
      if (word_ready) begin
        m_pending = 0;
        if (start) begin
          m_active = 1; m_bits.delete();
          if (bit_valid) m_bits.push_back(serial_in);
        end
      end
    end else if (start) begin
      m_active = 1; m_bits.delete();
      if (bit_valid) m_bits.push_back(serial_in);
    end else if (m_active && bit_valid) begin
      m_bits.push_back(serial_in);
      if (m_bits.size() == N) begin
        m_a = pack_bits();
        m_b = pattern_load ? pattern_in : m_pat;
        m_pending = 1; m_active = 0;
        m_bits.delete();
      end
    end
    if (pattern_load) m_pat = pattern_in;
    m_ovr = ovr_n;
  endtask

  initial forever begin
    @(posedge clk or negedge reset_n);
    model_step();
  end

  task automatic chk16(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk16("model a_out", a_out, m_a);
      chk16("model b_out", b_out, m_b);
      chk1("model word_valid", word_valid, m_pending);
      chk1("model busy", busy, m_active);
      chk1("model overrun", overrun, m_ovr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    start = 0; bit_valid = 0; serial_in = 0; pattern_load = 0;
  endtask

  task automatic send_word(input logic [N-1:0] w, input bit load_last, input logic [N-1:0] pin_last);
    for (int i = N - 1; i >= 0; i--) begin
      start = (i == N - 1);
      bit_valid = 1;
      serial_in = w[i];
      pattern_load = load_last && (i == 0);
      pattern_in = pin_last;
      tick();
    end
    idle_inputs();
  endtask

  task automatic accept();
    word_ready = 1; tick(); word_ready = 0;
    chk1("accept word_valid", word_valid, 1'b0);
  endtask

  initial begin
    logic [N-1:0] w, w2;
    int pulses, first_wv;

    repeat (3) tick();
    reset_n = 1; cmp_en = 1;
    chk16("reset a_out", a_out, '0);
    chk16("reset b_out", b_out, '0);
    chk1("reset word_valid", word_valid, 1'b0);
    chk1("reset busy", busy, 1'b0);
    chk1("reset overrun", overrun, 1'b0);

    // Reset after 7 bits of a word
    w = 16'($urandom);
    for (int i = 0; i < 7; i++) begin
      start = (i == 0); bit_valid = 1; serial_in = w[N-1-i]; tick();
    end
    idle_inputs();
    chk1("midshift busy", busy, 1'b1);
    #1 reset_n = 0;
    #1;
    chk1("async reset busy", busy, 1'b0);
    chk1("async reset word_valid", word_valid, 1'b0);
    chk16("async reset a_out", a_out, '0);
    tick(); reset_n = 1;
    w = 16'($urandom);
    send_word(w, 0, '0);
    chk1("fresh word_valid", word_valid, 1'b1);
    chk16("fresh a_out", a_out, w);
    chk16("fresh b_out", b_out, '0);
    accept();

    // Match path
    pattern_load = 1; pattern_in = 16'hA5C3; tick(); pattern_load = 0;
    send_word(16'hA5C3, 0, '0);
    chk1("match word_valid", word_valid, 1'b1);
    chk16("match a_out", a_out, 16'hA5C3);
    chk16("match b_out", b_out, 16'hA5C3);
    chk1("match compare", a_out == b_out, 1'b1);
    repeat (5) begin
      tick();
      chk1("stall word_valid", word_valid, 1'b1);
      chk16("stall a_out", a_out, 16'hA5C3);
      chk16("stall b_out", b_out, 16'hA5C3);
    end
    accept();

    // Mismatch with pattern loaded on the final bit
    pattern_load = 1; pattern_in = 16'hFFFF; tick(); pattern_load = 0;
    send_word(16'hFFFE, 1, 16'h1234);
    chk16("snapshot b_out", b_out, 16'h1234);
    chk16("snapshot a_out", a_out, 16'hFFFE);
    chk1("mismatch compare", a_out == b_out, 1'b0);
    accept();

    // Restart after 9 bits
    w = 16'($urandom);
    for (int i = 0; i < 9; i++) begin
      start = (i == 0); bit_valid = 1; serial_in = w[N-1-i]; tick();
    end
    start = 1; bit_valid = 1; serial_in = 1; tick();
    chk1("restart busy", busy, 1'b1);
    start = 0; serial_in = 0;
    repeat (15) tick();
    idle_inputs();
    chk1("restart word_valid", word_valid, 1'b1);
    chk16("restart a_out", a_out, 16'h8000);

    // Overrun in HOLD
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      bit_valid = (i < 3); serial_in = 1'($urandom); tick();
      if (overrun) pulses++;
    end
    idle_inputs();
    chk16("overrun pulses", 16'(pulses), 16'd3);
    chk1("overrun last", overrun, 1'b0);
    chk16("overrun a_out", a_out, 16'h8000);

    // Back-to-back: accept and start next word on the same edge
    w2 = 16'($urandom);
    word_ready = 1; start = 1; bit_valid = 1; serial_in = w2[N-1]; tick();
    word_ready = 0; start = 0;
    chk1("b2b word_valid low", word_valid, 1'b0);
    chk1("b2b busy", busy, 1'b1);
    first_wv = 0;
    for (int i = N - 2; i >= 0; i--) begin
      serial_in = w2[i]; tick();
      if (word_valid && first_wv == 0) first_wv = N - i;
    end
    idle_inputs();
    chk16("b2b latency", 16'(first_wv), 16'(N));
    chk16("b2b a_out", a_out, w2);

    // word_ready held high, idle bits ignored
    word_ready = 1; tick();
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1; serial_in = 1'($urandom); tick();
      chk1("idle busy", busy, 1'b0);
      chk1("idle overrun", overrun, 1'b0);
      chk1("idle word_valid", word_valid, 1'b0);
    end
    idle_inputs(); word_ready = 0;

    // Randomized traffic, model-checked every cycle
    for (int c = 0; c < 4000; c++) begin
      start        = ($urandom_range(0, 19) == 0);
      bit_valid    = ($urandom_range(0, 9) < 7);
      serial_in    = 1'($urandom);
      word_ready   = ($urandom_range(0, 2) == 0);
      pattern_load = ($urandom_range(0, 19) == 0);
      pattern_in   = 16'($urandom);
      tick();
      if (c % 1000 == 999) begin
        #1 reset_n = 0; #1;
        chk1("random reset busy", busy, 1'b0);
        tick(); reset_n = 1;
      end
    end
    idle_inputs(); word_ready = 0;
    tick();
    cmp_en = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
